// File: rtl/bcd_display_driver_pkg.sv
// Shared types and constants for the BCD display driver: converter FSM
// encodings and active-low {g,f,e,d,c,b,a} segment patterns.
package bcd_display_driver_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern, zero latency.
// Non-decimal codes 10..15 light nothing.
module seg7_decoder
  import bcd_display_driver_pkg::*;
(
  input  logic [3:0] bcd_in,
  output logic [6:0] seg_out
);

  always_comb begin
    seg_out = SEG_BLANK;
    case (bcd_in)
      4'd0: seg_out = SEG_0;
      4'd1: seg_out = SEG_1;
      4'd2: seg_out = SEG_2;
      4'd3: seg_out = SEG_3;
      4'd4: seg_out = SEG_4;
      4'd5: seg_out = SEG_5;
      4'd6: seg_out = SEG_6;
      4'd7: seg_out = SEG_7;
      4'd8: seg_out = SEG_8;
      4'd9: seg_out = SEG_9;
      default: seg_out = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Binary-to-BCD (double-dabble, one bit per cycle, 2*WIDTH+2 cycles per result)
// feeding a free-running multiplexed 7-segment scanner with leading-zero blanking.
module bcd_display_driver
  import bcd_display_driver_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 5,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [2*WIDTH-1:0]    bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     an_out
);

  localparam int BIN_W  = 2 * WIDTH;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int STEP_W = $clog2(BIN_W + 1);
  localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    shift_q, shift_d;
  logic [BCD_W-1:0]    scratch_q, scratch_d;
  logic [BCD_W-1:0]    scratch_adj;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                done_q, done_d;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [3:0]          digit_sel;
  logic                upper_zero;
  logic                blank;
  logic [6:0]          seg_raw;

  // Add-3 correction applied before each shift keeps every nibble decimal.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    step_d    = step_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shift_d   = bin_in;
          scratch_d = '0;
          step_d    = '0;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
        step_d = step_q + 1'b1;
        if (step_q == STEP_W'(BIN_W - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scan timing never looks at the converter; it only reads the committed result.
  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      step_q    <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      pre_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      step_q    <= step_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
    end
  end

  // Digit mux and blanking both read registered index and result, so a scan
  // step and a result update on the same edge show the new value at once.
  always_comb begin
    digit_sel  = 4'd0;
    an_out     = '1;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        digit_sel = bcd_q[4*i +: 4];
        an_out[i] = 1'b0;
      end
      if ((IDX_W'(i) >= idx_q) && (bcd_q[4*i +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    blank = (idx_q != '0) && upper_zero;
  end

  seg7_decoder u_seg7_decoder (
    .bcd_in  (digit_sel),
    .seg_out (seg_raw)
  );

  assign seg_out = blank ? SEG_BLANK : seg_raw;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: doc/bcd_display_driver.md
# bcd_display_driver

Downstream consumer of the multiply automaton's 2*Width-bit product. The block captures a binary result on a load strobe and converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed, active-low 7-segment display with leading-zero blanking.

## Interface
- WIDTH, 8, operand width of the upstream multiplier; the binary input is 2*WIDTH bits.
- DIGITS, 5, number of BCD digits and display positions. Must satisfy 10^DIGITS > 2^(2*WIDTH); the instantiator guarantees this.
- SCAN_DIV, 1000, clk cycles each digit stays lit.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  one clock; reset is synchronous and active-high.
- load  input  1  start conversion of bin_in; honoured only when busy=0.
- bin_in  input  2*WIDTH  unsigned binary value (product register output).
- busy  output  1  conversion in progress; load is ignored while high.
- done  output  1  one-cycle pulse; bcd_out is updated in the same cycle.
- bcd_out  output  4*DIGITS  packed BCD of the last completed conversion; digit 0 is in bits [3:0].
- seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an_out  output  DIGITS  digit enables, active-low one-hot.

## Operation
- Converter FSM has three states:
  - IDLE: load=1 captures bin_in into the shift register, clears the BCD scratch, clears the step count, and moves to CONV.
  - CONV: each cycle, add 3 to every scratch nibble ≥5, then shift {scratch, shift} left one bit. After 2*WIDTH steps, move to DONE.
  - DONE: load bcd_out from scratch, pulse done, return to IDLE.
- busy=1 in CONV and DONE. A load sampled in those states is dropped; there is no queueing.
- bin_in is sampled only at the accepting edge. Later changes do not affect the conversion in flight.
- Scan logic is free-running and independent of the FSM:
  - The prescaler counts 0..SCAN_DIV-1.
  - At wrap, the digit index increments 0..DIGITS-1, then back to 0.
- an_out has bit [index] low and all other bits high.
- seg_out shows the standard decode of bcd_out nibble[index].
- Blanking: seg_out=7'h7F when index>0 and every nibble at positions ≥index is zero. Digit 0 is never blanked.
- The display always shows bcd_out, so a conversion in flight never disturbs the displayed value.

## Timing
- Reset values (synchronous, at the first edge with rst=1):
  - state=IDLE, busy=0, done=0, bcd_out=0.
  - prescaler=0, index=0, an_out=~1, seg_out=7'b1000000 ("0").
- Latency: load accepted at edge E0, CONV occupies edges E1..E(2W), DONE at edge E(2W+1). Here W=WIDTH.
- busy is high in the cycles after E0 through E(2W+1). done is high for exactly the one cycle following E(2W+1), with the new bcd_out.
- Throughput: next accepted load is at E(2W+2) at the earliest, i.e. 2*WIDTH+2 cycles per conversion. For WIDTH=8 this is 18 cycles.
- rst asserted mid-conversion: all state returns to reset values at that edge, the partial result is discarded, and no done pulse is produced.
- rst overrides load on the same edge.
- Prescaler wrap coinciding with a bcd_out update: the new digit uses the new bcd_out value. No glitch state is allowed.

## Structure
- Shared package/include holds:
  - FSM encodings S_IDLE, S_CONV, S_DONE.
  - Segment constants SEG_0..SEG_9 and SEG_BLANK=7'h7F.
- Sub-module seg7_decoder: combinational, 4-bit BCD to 7-bit active-low pattern, with codes 10–15 mapped to SEG_BLANK. It is instantiated once, after the digit mux.
- The step counter width is $clog2(2*WIDTH+1).

## Test plan
- Reset during idle and mid-scan -> busy=0, done=0, bcd_out=0, an_out=5'b11110, seg_out=7'b1000000.
- load with bin_in=16'd65025 (255*255) -> done exactly 17 cycles after the accepting edge, bcd_out=20'h65025; busy high for those 17 cycles.
- bin_in=0, then 16'd1000, back-to-back at the earliest legal edge -> bcd_out=20'h00000, then 20'h01000; the second load is accepted 18 cycles after the first.
- load pulsed repeatedly while busy with differing bin_in -> only the first value converts; exactly one done pulse.
- rst asserted at the 8th CONV cycle of a 16'd4321 conversion -> outputs return to reset values and no done pulse. A fresh load of 16'd4321 then yields bcd_out=20'h04321.
- SCAN_DIV=4, bcd_out=20'h00012 -> an_out steps 11110, 11101, 11011, 10111, 01111 every 4 cycles. seg_out shows "2" (7'b0100100) and "1" (7'b1111001), then 7'h7F for digits 2–4.
